// File: rtl/lke_cam_cfg_tx_if.sv
// ---------------------------------------------------------------------------
// lke_cam_cfg_tx_if
//   Bundles the request, entry and control-stream signals of the CAM-write
//   packet builder.
//   slave  : packet builder view (accepts requests/entries, drives AXIS out)
//   master : requester / downstream view (drives requests/entries, tready)
//   Signals:
//     req_valid/req_ready, req_stage_id[4:0], req_lookup_id[2:0],
//     req_start_idx[7:0], req_num[4:0]              write request
//     ent_valid/ent_ready, ent_data[ENTRY_W-1:0]     CAM entry stream
//     c_m_axis_tdata/tuser/tkeep/tvalid/tlast/tready control AXIS output
//     busy, done, err                                status
// ---------------------------------------------------------------------------
interface lke_cam_cfg_tx_if #(
  parameter int C_S_AXIS_DATA_WIDTH  = 512,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int ENTRY_W              = 205
);
  logic                              req_valid;
  logic                              req_ready;
  logic [4:0]                        req_stage_id;
  logic [2:0]                        req_lookup_id;
  logic [7:0]                        req_start_idx;
  logic [4:0]                        req_num;

  logic                              ent_valid;
  logic                              ent_ready;
  logic [ENTRY_W-1:0]                ent_data;

  logic [C_S_AXIS_DATA_WIDTH-1:0]    c_m_axis_tdata;
  logic [C_S_AXIS_TUSER_WIDTH-1:0]   c_m_axis_tuser;
  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  c_m_axis_tkeep;
  logic                              c_m_axis_tvalid;
  logic                              c_m_axis_tlast;
  logic                              c_m_axis_tready;

  logic                              busy;
  logic                              done;
  logic                              err;

  modport slave (
    input  req_valid, req_stage_id, req_lookup_id, req_start_idx, req_num,
    input  ent_valid, ent_data,
    input  c_m_axis_tready,
    output req_ready, ent_ready,
    output c_m_axis_tdata, c_m_axis_tuser, c_m_axis_tkeep,
    output c_m_axis_tvalid, c_m_axis_tlast,
    output busy, done, err
  );

  modport master (
    output req_valid, req_stage_id, req_lookup_id, req_start_idx, req_num,
    output ent_valid, ent_data,
    output c_m_axis_tready,
    input  req_ready, ent_ready,
    input  c_m_axis_tdata, c_m_axis_tuser, c_m_axis_tkeep,
    input  c_m_axis_tvalid, c_m_axis_tlast,
    input  busy, done, err
  );
endinterface

// File: rtl/lke_cam_cfg_tx.sv
// ---------------------------------------------------------------------------
// lke_cam_cfg_tx
//   Builds one 512b AXIS control packet per CAM-write request: a header beat
//   carrying the control flag, module id and start index, followed by one
//   beat per CAM entry (entry left-aligned, then byte-reversed so the entry's
//   most significant byte lands in tdata[7:0]). Requests whose index range
//   falls outside the CAM are rejected with a one-cycle err pulse and produce
//   no output.
//   Ports:
//     clk, rst_n  clock, asynchronous active-low reset
//     bus         lke_cam_cfg_tx_if.slave (request, entry, AXIS, status)
// ---------------------------------------------------------------------------
module lke_cam_cfg_tx #(
  parameter int          C_S_AXIS_DATA_WIDTH  = 512,
  parameter int          C_S_AXIS_TUSER_WIDTH = 128,
  parameter int          ENTRY_W              = 205,
  parameter int          CAM_DEPTH            = 16,
  parameter logic [15:0] CTRL_FLAG            = 16'hf2f1
) (
  input  logic            clk,
  input  logic            rst_n,
  lke_cam_cfg_tx_if.slave bus
);

  localparam int         DW     = C_S_AXIS_DATA_WIDTH;
  localparam int         UW     = C_S_AXIS_TUSER_WIDTH;
  localparam int         NB     = DW / 8;
  localparam int         PAD_W  = DW - ENTRY_W;
  localparam logic [8:0] DEPTH9 = 9'(CAM_DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    ENT  = 2'd2,
    ERR  = 2'd3
  } state_t;

  state_t state, state_nx;

  // Output register stage
  logic [DW-1:0] tdata_p1;
  logic [UW-1:0] tuser_p1;
  logic [NB-1:0] tkeep_p1;
  logic          tlast_p1;
  logic          vld_p1;

  logic [4:0]    remaining;
  logic [15:0]   pkt_bytes;

  logic          req_ready_c;
  logic          ent_ready_c;
  logic          hdr_load;
  logic          ent_load;
  logic          req_bad;
  logic          beat_acc;
  logic [8:0]    req_end;
  logic [15:0]   req_bytes;
  logic [DW-1:0] hdr_beat;
  logic [DW-1:0] ent_beat;

  // Byte 0 of the result takes the most significant byte of v.
  function automatic logic [DW-1:0] byte_rev(input logic [DW-1:0] v);
    logic [DW-1:0] r;
    for (int i = 0; i < NB; i++) begin
      r[8*i +: 8] = v[8*(NB-1-i) +: 8];
    end
    return r;
  endfunction

  function automatic logic [UW-1:0] user_word(input logic [15:0] nbytes);
    logic [UW-1:0] u;
    u        = '0;
    u[15:0]  = nbytes;
    return u;
  endfunction

  // Request decode: 9b end index so start+num cannot wrap into range.
  assign req_end   = {1'b0, bus.req_start_idx} + {4'b0, bus.req_num};
  assign req_bad   = (bus.req_num == 5'd0)
                  || ({4'b0, bus.req_num} > DEPTH9)
                  || ({1'b0, bus.req_start_idx} >= DEPTH9)
                  || (req_end > DEPTH9);
  // Packet length in bytes: header plus one 64B beat per entry.
  assign req_bytes = {4'd0, ({1'b0, bus.req_num} + 6'd1), 6'd0};

  always_comb begin
    hdr_beat            = '0;
    hdr_beat[335:320]   = CTRL_FLAG;
    hdr_beat[375:368]   = {bus.req_stage_id, bus.req_lookup_id};
    hdr_beat[391:384]   = bus.req_start_idx;
  end

  assign ent_beat = byte_rev({bus.ent_data, {PAD_W{1'b0}}});
  assign beat_acc = vld_p1 & bus.c_m_axis_tready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    req_ready_c = 1'b0;
    ent_ready_c = 1'b0;
    hdr_load    = 1'b0;
    ent_load    = 1'b0;
    case (state)
      IDLE: begin
        // The output register is always empty here, so the header can be
        // loaded on the accept edge (header visible one cycle later).
        req_ready_c = 1'b1;
        if (bus.req_valid) begin
          state_nx = req_bad ? ERR : HDR;
          hdr_load = !req_bad;
        end
      end
      HDR: begin
        if (beat_acc) state_nx = ENT;
      end
      ENT: begin
        ent_ready_c = (remaining != 5'd0) && (!vld_p1 || bus.c_m_axis_tready);
        ent_load    = ent_ready_c && bus.ent_valid;
        if (beat_acc && tlast_p1) state_nx = IDLE;
      end
      ERR: begin
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // ---- stage p1: output register, holds while vld_p1 && !tready ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tdata_p1  <= '0;
      tuser_p1  <= '0;
      tkeep_p1  <= '0;
      tlast_p1  <= 1'b0;
      vld_p1    <= 1'b0;
      remaining <= 5'd0;
      pkt_bytes <= 16'd0;
    end else if (hdr_load) begin
      tdata_p1  <= hdr_beat;
      tuser_p1  <= user_word(req_bytes);
      tkeep_p1  <= '1;
      tlast_p1  <= 1'b0;
      vld_p1    <= 1'b1;
      remaining <= bus.req_num;
      pkt_bytes <= req_bytes;
    end else if (ent_load) begin
      tdata_p1  <= ent_beat;
      tuser_p1  <= user_word(pkt_bytes);
      tkeep_p1  <= '1;
      tlast_p1  <= (remaining == 5'd1);
      vld_p1    <= 1'b1;
      remaining <= remaining - 5'd1;
    end else if (bus.c_m_axis_tready) begin
      vld_p1    <= 1'b0;
      tlast_p1  <= 1'b0;
    end
  end

  assign bus.c_m_axis_tdata  = tdata_p1;
  assign bus.c_m_axis_tuser  = tuser_p1;
  assign bus.c_m_axis_tkeep  = tkeep_p1;
  assign bus.c_m_axis_tlast  = tlast_p1;
  assign bus.c_m_axis_tvalid = vld_p1;

  // req_ready is gated by rst_n so every output reads 0 while in reset.
  assign bus.req_ready = req_ready_c & rst_n;
  assign bus.ent_ready = ent_ready_c;
  assign bus.busy      = (state != IDLE);
  assign bus.done      = beat_acc & tlast_p1;
  assign bus.err       = (state == ERR);

endmodule

// File: tb/tb_lke_cam_cfg_tx.sv
module tb_lke_cam_cfg_tx;

  logic clk;
  logic rst_n;

  lke_cam_cfg_tx_if bus ();

  lke_cam_cfg_tx dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  int done_cnt   = 0;
  int err_cycles = 0;
  int vld_cycles = 0;

  logic [511:0] q_data [$];
  logic         q_last [$];
  logic [127:0] q_user [$];

  logic [204:0] ent_tab [16];
  bit           abort;
  bit           stop;

  // Passive capture of every handshaked beat and status activity.
  always @(negedge clk) begin
    if (bus.c_m_axis_tvalid) vld_cycles++;
    if (bus.err)             err_cycles++;
    if (bus.done)            done_cnt++;
    if (bus.c_m_axis_tvalid && bus.c_m_axis_tready) begin
      q_data.push_back(bus.c_m_axis_tdata);
      q_last.push_back(bus.c_m_axis_tlast);
      q_user.push_back(bus.c_m_axis_tuser);
    end
  end

  function automatic logic [511:0] brev(input logic [511:0] d);
    logic [511:0] r;
    for (int i = 0; i < 64; i++) r[8*i +: 8] = d[511-8*i -: 8];
    return r;
  endfunction

  function automatic logic [511:0] exp_hdr(input logic [7:0] id, input logic [7:0] idx);
    logic [511:0] r;
    r          = '0;
    r[335:320] = 16'hf2f1;
    r[375:368] = id;
    r[391:384] = idx;
    return r;
  endfunction

  function automatic logic [511:0] pad(input logic [204:0] e);
    return {e, 307'd0};
  endfunction

  task automatic send_req(input logic [4:0] st, input logic [2:0] lk,
                          input logic [7:0] idx, input logic [4:0] num);
    bit got;
    int c;
    bus.req_stage_id  = st;
    bus.req_lookup_id = lk;
    bus.req_start_idx = idx;
    bus.req_num       = num;
    bus.req_valid     = 1'b1;
    got = 0;
    c   = 0;
    while (!got && c < 100) begin
      @(negedge clk);
      if (bus.req_ready) got = 1;
      @(posedge clk); #1;
      c++;
    end
    bus.req_valid = 1'b0;
    if (!got) begin
      n_chk++;
      $display("FAIL req_accept timeout: req_ready=0 required=1");
    end
  endtask

  task automatic feed_entries(input int first, input int n, input bit gaps);
    bit got;
    int c;
    for (int i = 0; i < n; i++) begin
      if (abort) break;
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end
      bus.ent_valid = 1'b1;
      bus.ent_data  = ent_tab[first+i];
      got = 0;
      c   = 0;
      while (!got && !abort && c < 300) begin
        @(negedge clk);
        if (bus.ent_ready) got = 1;
        @(posedge clk); #1;
        c++;
      end
      bus.ent_valid = 1'b0;
      if (!got && !abort) begin
        n_chk++;
        $display("FAIL ent_accept timeout entry %0d: ent_ready=0 required=1", i);
      end
    end
  endtask

  task automatic wait_done(input int target);
    int c;
    c = 0;
    while (done_cnt < target && c < 500) begin
      @(posedge clk); #1;
      c++;
    end
    if (done_cnt < target) begin
      n_chk++;
      $display("FAIL done timeout: done_cnt=%0d required=%0d", done_cnt, target);
    end
  endtask

  task automatic test_reset();
    rst_n               = 1'b0;
    bus.req_valid       = 1'b0;
    bus.req_stage_id    = '0;
    bus.req_lookup_id   = '0;
    bus.req_start_idx   = '0;
    bus.req_num         = '0;
    bus.ent_valid       = 1'b0;
    bus.ent_data        = '0;
    bus.c_m_axis_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if ({bus.c_m_axis_tvalid, bus.c_m_axis_tlast, bus.busy, bus.done, bus.err,
         bus.req_ready, bus.ent_ready} !== 7'b0)
      $display("FAIL reset_ctrl got %b required 0000000", {bus.c_m_axis_tvalid,
               bus.c_m_axis_tlast, bus.busy, bus.done, bus.err, bus.req_ready, bus.ent_ready});
    else n_pass++;
    n_chk++;
    if ({bus.c_m_axis_tdata, bus.c_m_axis_tuser, bus.c_m_axis_tkeep} !== '0)
      $display("FAIL reset_data got nonzero tdata/tuser/tkeep required 0");
    else n_pass++;
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_chk++;
    if ({bus.req_ready, bus.busy} !== 2'b10)
      $display("FAIL idle_after_reset got req_ready,busy=%b required 10", {bus.req_ready, bus.busy});
    else n_pass++;
  endtask

  task automatic test_single();
    int b, d0;
    logic [511:0] rv;
    b  = q_data.size();
    d0 = done_cnt;
    ent_tab[0] = {1'b1, 204'h23456789abcdef01_23456789abcdef01_23456789abcdef01_123};
    send_req(5'd2, 3'd2, 8'd3, 5'd1);
    n_chk++;
    if ({bus.c_m_axis_tvalid, bus.busy} !== 2'b11)
      $display("FAIL hdr_latency got tvalid,busy=%b required 11", {bus.c_m_axis_tvalid, bus.busy});
    else n_pass++;
    n_chk++;
    if (bus.c_m_axis_tdata !== exp_hdr(8'h12, 8'd3))
      $display("FAIL hdr1 got %h required %h", bus.c_m_axis_tdata, exp_hdr(8'h12, 8'd3));
    else n_pass++;
    n_chk++;
    if (bus.c_m_axis_tkeep !== {64{1'b1}})
      $display("FAIL tkeep got %h required all ones", bus.c_m_axis_tkeep);
    else n_pass++;
    feed_entries(0, 1, 0);
    wait_done(d0 + 1);
    n_chk++;
    if (q_data.size() - b !== 2)
      $display("FAIL single_beats got %0d required 2", q_data.size() - b);
    else n_pass++;
    if (q_data.size() - b >= 2) begin
      rv = brev(q_data[b+1]);
      n_chk++;
      if (rv !== pad(ent_tab[0]))
        $display("FAIL single_entry got %h required %h", rv, pad(ent_tab[0]));
      else n_pass++;
      rv = q_data[b+1];
      n_chk++;
      if (rv[7:0] !== 8'h91)
        $display("FAIL single_lsbyte got %h required 91", rv[7:0]);
      else n_pass++;
      n_chk++;
      if ({q_last[b], q_last[b+1]} !== 2'b01)
        $display("FAIL single_tlast got %b required 01", {q_last[b], q_last[b+1]});
      else n_pass++;
      n_chk++;
      if (q_user[b] !== 128'd128 || q_user[b+1] !== 128'd128)
        $display("FAIL single_tuser got %0d/%0d required 128/128", q_user[b], q_user[b+1]);
      else n_pass++;
    end
    n_chk++;
    if (done_cnt - d0 !== 1)
      $display("FAIL single_done got %0d required 1", done_cnt - d0);
    else n_pass++;
    n_chk++;
    if ({bus.c_m_axis_tvalid, bus.busy} !== 2'b00)
      $display("FAIL single_end got tvalid,busy=%b required 00", {bus.c_m_axis_tvalid, bus.busy});
    else n_pass++;
  endtask

  task automatic test_full();
    int b, d0;
    logic [511:0] rv;
    b  = q_data.size();
    d0 = done_cnt;
    for (int i = 0; i < 16; i++) ent_tab[i] = {5{41'(i * 1000 + 17)}};
    send_req(5'd31, 3'd7, 8'd0, 5'd16);
    feed_entries(0, 16, 0);
    wait_done(d0 + 1);
    n_chk++;
    if (q_data.size() - b !== 17)
      $display("FAIL full_beats got %0d required 17", q_data.size() - b);
    else n_pass++;
    if (q_data.size() - b >= 17) begin
      n_chk++;
      if (q_data[b] !== exp_hdr(8'hff, 8'd0))
        $display("FAIL full_hdr got %h required %h", q_data[b], exp_hdr(8'hff, 8'd0));
      else n_pass++;
      n_chk++;
      if (q_user[b] !== 128'd1088)
        $display("FAIL full_tuser got %0d required 1088", q_user[b]);
      else n_pass++;
      for (int k = 0; k < 17; k++) begin
        n_chk++;
        if (q_last[b+k] !== (k == 16))
          $display("FAIL full_tlast beat %0d got %b required %b", k, q_last[b+k], (k == 16));
        else n_pass++;
      end
      for (int k = 1; k < 17; k++) begin
        rv = brev(q_data[b+k]);
        n_chk++;
        if (rv !== pad(ent_tab[k-1]))
          $display("FAIL full_entry beat %0d got %h required %h", k, rv, pad(ent_tab[k-1]));
        else n_pass++;
      end
    end
  endtask

  task automatic test_illegal();
    logic [7:0] idx_t [3];
    logic [4:0] num_t [3];
    int e0, v0, b, d0;
    idx_t[0] = 8'd14; num_t[0] = 5'd3;
    idx_t[1] = 8'd0;  num_t[1] = 5'd0;
    idx_t[2] = 8'd16; num_t[2] = 5'd1;
    for (int i = 0; i < 3; i++) begin
      e0 = err_cycles;
      v0 = vld_cycles;
      send_req(5'd1, 3'd1, idx_t[i], num_t[i]);
      repeat (3) begin @(posedge clk); #1; end
      n_chk++;
      if (err_cycles - e0 !== 1)
        $display("FAIL illegal%0d_err got %0d cycles required 1", i, err_cycles - e0);
      else n_pass++;
      n_chk++;
      if (vld_cycles - v0 !== 0)
        $display("FAIL illegal%0d_tvalid got %0d cycles required 0", i, vld_cycles - v0);
      else n_pass++;
    end
    // Highest legal index: must not be rejected.
    e0 = err_cycles;
    b  = q_data.size();
    d0 = done_cnt;
    ent_tab[0] = {5{41'h15555555555}};
    send_req(5'd0, 3'd1, 8'd15, 5'd1);
    feed_entries(0, 1, 0);
    wait_done(d0 + 1);
    n_chk++;
    if (err_cycles - e0 !== 0 || q_data.size() - b !== 2)
      $display("FAIL edge_legal got err=%0d beats=%0d required err=0 beats=2",
               err_cycles - e0, q_data.size() - b);
    else n_pass++;
  endtask

  task automatic test_stall();
    int b, d0;
    bit prev_stall;
    logic [511:0] prev_d;
    logic         prev_l;
    logic [511:0] rv;
    b  = q_data.size();
    d0 = done_cnt;
    for (int i = 0; i < 4; i++) ent_tab[i] = {5{41'(64'h0123456789 + i)}};
    stop = 0;
    prev_stall = 0;
    prev_d = '0;
    prev_l = 1'b0;
    fork
      begin
        send_req(5'd4, 3'd3, 8'd8, 5'd4);
        feed_entries(0, 4, 1);
        wait_done(d0 + 1);
        stop = 1;
      end
      begin
        while (!stop) begin
          @(posedge clk); #1;
          bus.c_m_axis_tready = 1'($urandom_range(0, 1));
        end
      end
      begin
        while (!stop) begin
          @(negedge clk);
          if (prev_stall) begin
            n_chk++;
            if ({bus.c_m_axis_tvalid, bus.c_m_axis_tlast, bus.c_m_axis_tdata} !== {1'b1, prev_l, prev_d})
              $display("FAIL stall_hold got tvalid=%b tlast=%b tdata=%h required tvalid=1 tlast=%b tdata=%h",
                       bus.c_m_axis_tvalid, bus.c_m_axis_tlast, bus.c_m_axis_tdata, prev_l, prev_d);
            else n_pass++;
          end
          prev_stall = bus.c_m_axis_tvalid && !bus.c_m_axis_tready;
          prev_d     = bus.c_m_axis_tdata;
          prev_l     = bus.c_m_axis_tlast;
        end
      end
    join
    bus.c_m_axis_tready = 1'b1;
    n_chk++;
    if (q_data.size() - b !== 5)
      $display("FAIL stall_beats got %0d required 5", q_data.size() - b);
    else n_pass++;
    if (q_data.size() - b >= 5) begin
      n_chk++;
      if (q_data[b] !== exp_hdr(8'h23, 8'd8))
        $display("FAIL stall_hdr got %h required %h", q_data[b], exp_hdr(8'h23, 8'd8));
      else n_pass++;
      for (int k = 1; k < 5; k++) begin
        rv = brev(q_data[b+k]);
        n_chk++;
        if (rv !== pad(ent_tab[k-1]) || q_last[b+k] !== (k == 4))
          $display("FAIL stall_entry beat %0d got %h last=%b required %h last=%b",
                   k, rv, q_last[b+k], pad(ent_tab[k-1]), (k == 4));
        else n_pass++;
      end
    end
  endtask

  task automatic test_reset_mid();
    int b, d0, c;
    logic [511:0] rv;
    b = q_data.size();
    for (int i = 0; i < 8; i++) ent_tab[i] = {5{41'(i + 100)}};
    abort = 0;
    fork
      begin
        send_req(5'd5, 3'd0, 8'd0, 5'd8);
        feed_entries(0, 8, 0);
      end
      begin
        c = 0;
        while (q_data.size() < b + 2 && c < 100) begin
          @(posedge clk); #1;
          c++;
        end
        #1;
        n_chk++;
        if (bus.c_m_axis_tvalid !== 1'b1)
          $display("FAIL beat3_present got tvalid=%b required 1", bus.c_m_axis_tvalid);
        else n_pass++;
        rst_n = 1'b0;
        #1;
        n_chk++;
        if ({bus.c_m_axis_tvalid, bus.c_m_axis_tlast, bus.busy, bus.done, bus.err,
             bus.req_ready, bus.ent_ready} !== 7'b0)
          $display("FAIL midrst_ctrl got %b required 0000000", {bus.c_m_axis_tvalid,
                   bus.c_m_axis_tlast, bus.busy, bus.done, bus.err, bus.req_ready, bus.ent_ready});
        else n_pass++;
        n_chk++;
        if ({bus.c_m_axis_tdata, bus.c_m_axis_tuser, bus.c_m_axis_tkeep} !== '0)
          $display("FAIL midrst_data got nonzero tdata/tuser/tkeep required 0");
        else n_pass++;
        abort = 1;
      end
    join
    abort = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    b  = q_data.size();
    d0 = done_cnt;
    ent_tab[0] = {5{41'h0abcdef0123}};
    send_req(5'd6, 3'd4, 8'd0, 5'd1);
    feed_entries(0, 1, 0);
    wait_done(d0 + 1);
    n_chk++;
    if (q_data.size() - b !== 2)
      $display("FAIL post_rst_beats got %0d required 2", q_data.size() - b);
    else n_pass++;
    if (q_data.size() - b >= 2) begin
      rv = brev(q_data[b+1]);
      n_chk++;
      if (q_data[b] !== exp_hdr(8'h34, 8'd0) || rv !== pad(ent_tab[0]) ||
          {q_last[b], q_last[b+1]} !== 2'b01)
        $display("FAIL post_rst_pkt got hdr=%h ent=%h last=%b required hdr=%h ent=%h last=01",
                 q_data[b], rv, {q_last[b], q_last[b+1]}, exp_hdr(8'h34, 8'd0), pad(ent_tab[0]));
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    int b, d0;
    logic [511:0] rv;
    b  = q_data.size();
    d0 = done_cnt;
    ent_tab[0] = {5{41'h11111111111}};
    ent_tab[1] = {5{41'h02222222222}};
    ent_tab[2] = {5{41'h13333333333}};
    send_req(5'd1, 3'd5, 8'd4, 5'd2);
    feed_entries(0, 2, 0);
    send_req(5'd3, 3'd1, 8'd9, 5'd1);
    feed_entries(2, 1, 0);
    wait_done(d0 + 2);
    n_chk++;
    if (done_cnt - d0 !== 2)
      $display("FAIL b2b_done got %0d required 2", done_cnt - d0);
    else n_pass++;
    n_chk++;
    if (q_data.size() - b !== 5)
      $display("FAIL b2b_beats got %0d required 5", q_data.size() - b);
    else n_pass++;
    if (q_data.size() - b >= 5) begin
      n_chk++;
      if (q_data[b] !== exp_hdr(8'h0d, 8'd4))
        $display("FAIL b2b_hdr1 got %h required %h", q_data[b], exp_hdr(8'h0d, 8'd4));
      else n_pass++;
      n_chk++;
      if (q_data[b+3] !== exp_hdr(8'h19, 8'd9))
        $display("FAIL b2b_hdr2 got %h required %h", q_data[b+3], exp_hdr(8'h19, 8'd9));
      else n_pass++;
      n_chk++;
      if ({q_last[b], q_last[b+1], q_last[b+2], q_last[b+3], q_last[b+4]} !== 5'b00101)
        $display("FAIL b2b_tlast got %b required 00101",
                 {q_last[b], q_last[b+1], q_last[b+2], q_last[b+3], q_last[b+4]});
      else n_pass++;
      n_chk++;
      if (q_user[b+2] !== 128'd192 || q_user[b+4] !== 128'd128)
        $display("FAIL b2b_tuser got %0d/%0d required 192/128", q_user[b+2], q_user[b+4]);
      else n_pass++;
      rv = brev(q_data[b+2]);
      n_chk++;
      if (rv !== pad(ent_tab[1]))
        $display("FAIL b2b_ent2 got %h required %h", rv, pad(ent_tab[1]));
      else n_pass++;
      rv = brev(q_data[b+4]);
      n_chk++;
      if (rv !== pad(ent_tab[2]))
        $display("FAIL b2b_ent3 got %h required %h", rv, pad(ent_tab[2]));
      else n_pass++;
    end
  endtask

  initial begin
    abort = 0;
    stop  = 0;
    test_reset();
    test_single();
    test_full();
    test_illegal();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
